// File: rtl/updown_prescaled_counter.sv
// updown_prescaled_counter: prescaled up/down counter with wrap/saturate, tc pulse and sticky ovf
module updown_prescaled_counter #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             preset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             ovf
);
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d, step_val;
  logic             tc_q, ovf_q, boundary;
  assign tick  = reset & enable & (pre_q >= prescale) & ~preset;
  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  // next count and boundary detection; counts above limit fold back to limit on a down step
  always_comb begin
    boundary = tick & (up_down ? (count_q >= limit) : (count_q == '0));
    step_val = up_down ? ((count_q < limit) ? count_q + WIDTH'(1) : (sat_mode ? limit : '0))
                       : ((count_q == '0) ? (sat_mode ? '0 : limit)
                                          : ((count_q > limit) ? limit : count_q - WIDTH'(1)));
    count_d  = preset ? ((load_value <= limit) ? load_value : limit) : (tick ? step_val : count_q);
    pre_d    = (preset || tick) ? '0 : (enable ? pre_q + PRE_W'(1) : pre_q);
  end
  // state registers; ovf set beats a coincident clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      tc_q    <= boundary;
      ovf_q   <= boundary | (ovf_q & ~ovf_clr);
    end
  end
endmodule

// File: tb/tb_updown_prescaled_counter.sv
// tb_updown_prescaled_counter: directed and random checks against a behavioural model
module tb_updown_prescaled_counter;
  logic        clk = 1'b0;
  logic        reset, enable, preset, up_down, sat_mode, ovf_clr;
  logic [7:0]  load_value, limit, count;
  logic [15:0] prescale;
  logic        tick, tc, ovf;
  int          total = 0, passed = 0, nfail = 0;
  int          m_count = 0, m_pre = 0;
  bit          m_tc = 0, m_ovf = 0;

  updown_prescaled_counter #(.WIDTH(8), .PRE_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .preset(preset), .load_value(load_value),
    .up_down(up_down), .sat_mode(sat_mode), .limit(limit), .prescale(prescale),
    .ovf_clr(ovf_clr), .count(count), .tick(tick), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_tick();
    return reset && enable && !preset && (m_pre >= int'(prescale));
  endfunction

  // model of one rising edge, from the counting rules in plain integer arithmetic
  task automatic model_edge();
    int lim;
    bit t, ev;
    lim = int'(limit);
    t   = model_tick();
    ev  = 0;
    if (!reset) begin
      m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
      return;
    end
    if (preset) begin
      m_count = (int'(load_value) > lim) ? lim : int'(load_value);
      m_pre   = 0;
    end else if (t) begin
      m_pre = 0;
      if (up_down) begin
        if (m_count < lim) m_count++;
        else begin ev = 1; m_count = sat_mode ? lim : 0; end
      end else begin
        if (m_count == 0) begin ev = 1; m_count = sat_mode ? 0 : lim; end
        else m_count = (m_count > lim) ? lim : m_count - 1;
      end
    end else if (enable) m_pre++;
    m_tc  = ev;
    m_ovf = ev || (m_ovf && !ovf_clr);
  endtask

  task automatic step();
    #2;
    chk("tick", tick, model_tick());
    @(posedge clk);
    model_edge();
    #1;
    chk("count", count, m_count);
    chk("tc", tc, m_tc);
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 0; enable = 0; preset = 0; load_value = 0; up_down = 1; sat_mode = 0;
    limit = 255; prescale = 0; ovf_clr = 0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tick", tick, 0);
    @(posedge clk); #1;
    // full up-wrap sweep with prescale 0
    reset = 1; enable = 1;
    run(255);
    chk("sweep_255", count, 255);
    step();
    chk("wrap_0", count, 0);
    chk("wrap_tc", tc, 1);
    chk("wrap_ovf", ovf, 1);
    step();
    chk("tc_one_cycle", tc, 0);
    // prescale 3 with an enable gap mid-period
    ovf_clr = 1; prescale = 3; step(); ovf_clr = 0;
    run(6);
    enable = 0; run(5);
    enable = 1; run(10);
    // down saturate from 2, ovf clear and set priority
    limit = 10; prescale = 0; up_down = 0; sat_mode = 1; load_value = 2; preset = 1;
    step(); preset = 0;
    chk("preset_2", count, 2);
    run(5);
    chk("sat_hold0", count, 0);
    enable = 0; ovf_clr = 1; step();
    chk("ovf_cleared", ovf, 0);
    enable = 1; step();
    chk("ovf_set_wins", ovf, 1);
    ovf_clr = 0;
    // preset clamp and preset priority over a step
    limit = 100; up_down = 1; sat_mode = 0; load_value = 200; preset = 1;
    step();
    chk("clamp_100", count, 100);
    load_value = 50; step(); preset = 0;
    chk("preset_no_inc", count, 50);
    chk("preset_tc0", tc, 0);
    prescale = 2; run(7);
    // limit 9 wrap both ways, then lower limit above count
    prescale = 0; limit = 9; load_value = 9; preset = 1; step(); preset = 0;
    step();
    chk("l9_wrap0", count, 0);
    chk("l9_tc", tc, 1);
    up_down = 0; step();
    chk("l9_wrap9", count, 9);
    chk("l9_tc_dn", tc, 1);
    limit = 5; step();
    chk("fold_5", count, 5);
    up_down = 1; step();
    chk("l5_boundary", tc, 1);
    // limit 0 keeps count at 0, every tick a boundary
    limit = 0; run(3);
    chk("lim0_count", count, 0);
    chk("lim0_tc", tc, 1);
    // async reset mid-period with count 37
    limit = 255; load_value = 37; preset = 1; step(); preset = 0;
    prescale = 2; step();
    #1 reset = 0;
    #1;
    m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
    chk("arst_count", count, 0);
    chk("arst_tc", tc, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_tick", tick, 0);
    reset = 1;
    run(2);
    chk("no_step_yet", count, 0);
    step();
    chk("first_step", count, 1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) != 0);
      enable     = ($urandom_range(0, 3) != 0);
      preset     = ($urandom_range(0, 19) == 0);
      load_value = 8'($urandom);
      up_down    = 1'($urandom);
      sat_mode   = 1'($urandom);
      ovf_clr    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) limit = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      if ($urandom_range(0, 15) == 0) prescale = 16'($urandom_range(0, 3));
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/updown_prescaled_counter.md
UPDOWN_PRESCALED_COUNTER -- requirements
Module: updown_prescaled_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the count width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRE_W, default 16, giving the prescaler width in bits (legal range 1..31).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1, which advances the prescaler when high.
REQ-006 The block SHALL have port preset, input, 1, which loads load_value.
REQ-007 The block SHALL have port load_value, input, WIDTH, the preset value.
REQ-008 The block SHALL have port up_down, input, 1, selecting direction: 1 = up, 0 = down.
REQ-009 The block SHALL have port sat_mode, input, 1, selecting boundary behaviour: 1 = saturate, 0 = wrap.
REQ-010 The block SHALL have port limit, input, WIDTH, the upper bound; the count range is 0..limit.
REQ-011 The block SHALL have port prescale, input, PRE_W; one step occurs per prescale+1 enabled cycles.
REQ-012 The block SHALL have port ovf_clr, input, 1, which clears the sticky ovf flag.
REQ-013 The block SHALL have port count, output, WIDTH, the registered count value.
REQ-014 The block SHALL have port tick, output, 1, the combinational step strobe.
REQ-015 The block SHALL have port tc, output, 1, a registered one-cycle terminal-count pulse.
REQ-016 The block SHALL have port ovf, output, 1, the registered sticky boundary flag.

Function
REQ-017 The internal prescaler pre_cnt (PRE_W bits) SHALL define match as pre_cnt >= prescale; using >= covers a prescale value lowered below pre_cnt.
REQ-018 tick SHALL equal reset AND enable AND match AND NOT preset.
REQ-019 pre_cnt SHALL update as follows: on tick it goes to 0; otherwise, when enable is high, it increments; when enable is low, it holds.
REQ-020 With prescale = 0, tick SHALL assert on every enabled cycle.
REQ-021 When preset is high, the clock edge SHALL load count with load_value if load_value <= limit, else with limit; SHALL clear pre_cnt to 0; and SHALL do so regardless of enable.
REQ-022 preset SHALL take priority over a step in the same cycle; no tc pulse and no ovf set result from the load.
REQ-023 On an up tick with count < limit, count SHALL become count+1.
REQ-024 An up tick with count >= limit SHALL be a boundary event: in wrap mode count goes to 0; in saturate mode count goes to limit.
REQ-025 On a down tick with count > 0, count SHALL become count-1; if count > limit, count SHALL become limit instead.
REQ-026 A down tick with count = 0 SHALL be a boundary event: in wrap mode count goes to limit; in saturate mode count holds at 0.
REQ-027 With limit = 0, count SHALL remain 0 and every tick SHALL be a boundary event.
REQ-028 tc SHALL be high for exactly the one cycle following the edge that processed a boundary event, and low otherwise.
REQ-029 Consecutive boundary ticks SHALL give tc high on consecutive cycles, one per event.
REQ-030 ovf SHALL set on the edge that processes any boundary event and SHALL clear on an edge with ovf_clr high.
REQ-031 When a boundary event and ovf_clr coincide, the set SHALL win.
REQ-032 All arithmetic SHALL be unsigned and modulo 2^WIDTH, with no intermediate overflow; count SHALL never exceed limit after any step or load.
REQ-033 Changes to up_down, sat_mode and limit SHALL take effect on the next tick, with no pipeline delay.

Reset
REQ-034 While reset is low, count, pre_cnt, tc and ovf SHALL be 0 immediately, without a clock edge, and tick SHALL be 0.
REQ-035 Reset assertion mid-count SHALL discard any prescaler progress.
REQ-036 After reset deasserts, the first tick SHALL occur after prescale+1 enabled cycles.

Verification
REQ-037 WIDTH=8, prescale=0, limit=255, up, wrap, enable=1 from reset -> count=255 after 255 cycles; next edge count=0, tc=1 for one cycle, ovf=1.
REQ-038 prescale=3, limit=255, up -> count increments every 4th enabled cycle; enable low for 5 cycles mid-period -> count and pre_cnt hold, then the period resumes where it stopped.
REQ-039 limit=10, down, saturate, preset load_value=2, prescale=0 -> count 2,1,0,0,0; tc=1 after each step from 0; ovf=1; ovf_clr pulse with no event -> ovf=0; ovf_clr coinciding with an event -> ovf stays 1.
REQ-040 limit=100, preset load_value=200 -> count=100; preset high in a tick-eligible cycle -> count=load_value, no increment, tc=0, pre_cnt=0.
REQ-041 limit=9, up, wrap, count=9 -> 0 with a tc pulse; switch to down at 0 -> 9 with a tc pulse; lower limit to 5 while count=9, down tick -> 5, up tick -> boundary.
REQ-042 Reset low asynchronously mid-period with count=37 -> count=0, tc=0, ovf=0 before the next edge; release with prescale=2 -> first increment after 3 enabled cycles.
